// File: rtl/ring_counter_run_controller_if.sv
// Signal bundle between the run controller, its requester and the ring counter.
//
// Request handshake: a run request transfers on a rising edge where
// Run_Valid_In and Run_Ready_Out are both high and Abort_In is low. The
// requester holds Run_Valid_In and Run_Cycles_In stable until that edge.
// Run_Ready_Out depends only on controller state, never on Run_Valid_In.
// The Run_Done_Out / Run_Aborted_Out / Final_Count_Out completion report and
// the counter Start/Stop pulses are single-cycle and are not back-pressured.
interface ring_counter_run_controller_if #(
    parameter int CYCLES_WIDTH = 16
);
    // Requester side
    logic                    Run_Valid_In;
    logic                    Run_Ready_Out;
    logic [CYCLES_WIDTH-1:0] Run_Cycles_In;
    logic                    Abort_In;
    logic                    Error_Clear_In;
    logic                    Run_Busy_Out;
    logic                    Run_Done_Out;
    logic                    Run_Aborted_Out;
    logic [3:0]              Final_Count_Out;
    logic                    Error_Out;

    // Ring counter side
    logic                    Start_Counter_Command_Out;
    logic                    Stop_Counter_Command_Out;
    logic                    Counter_Running_Flag_In;
    logic [3:0]              Counter_Count_In;

    // Controller view
    modport slave (
        input  Run_Valid_In,
        input  Run_Cycles_In,
        input  Abort_In,
        input  Error_Clear_In,
        input  Counter_Running_Flag_In,
        input  Counter_Count_In,
        output Run_Ready_Out,
        output Run_Busy_Out,
        output Run_Done_Out,
        output Run_Aborted_Out,
        output Final_Count_Out,
        output Error_Out,
        output Start_Counter_Command_Out,
        output Stop_Counter_Command_Out
    );

    // Environment view (requester plus ring counter)
    modport master (
        output Run_Valid_In,
        output Run_Cycles_In,
        output Abort_In,
        output Error_Clear_In,
        output Counter_Running_Flag_In,
        output Counter_Count_In,
        input  Run_Ready_Out,
        input  Run_Busy_Out,
        input  Run_Done_Out,
        input  Run_Aborted_Out,
        input  Final_Count_Out,
        input  Error_Out,
        input  Start_Counter_Command_Out,
        input  Stop_Counter_Command_Out
    );
endinterface

// File: rtl/ring_counter_run_controller.sv
// Run sequencer for a 4-bit ring counter.
//
// Accepts a run length N, pulses Start, waits for the counter's running flag,
// lets it run for exactly N cycles, pulses Stop, waits for the flag to drop
// and reports completion with the captured one-hot count. A counter that does
// not acknowledge Start or Stop within ACK_TIMEOUT cycles of the command pulse
// (the pulse cycle itself counts as the first), or that stops on its own while
// running, parks the controller in ERROR until Error_Clear_In.
//
// ACK_TIMEOUT must be at least 2: the pulse cycle plus one wait cycle.
module ring_counter_run_controller #(
    parameter int CYCLES_WIDTH = 16,
    parameter int ACK_TIMEOUT  = 8
) (
    input  logic                          Clk_In,
    input  logic                          Reset_N_In,
    ring_counter_run_controller_if.slave  bus,
    output logic [2:0]                    Debug_State_Out
);

    localparam int TO_W = $clog2(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_RUN  = 3'd2,
        S_RUNNING   = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HALT = 3'd5,
        S_DONE      = 3'd6,
        S_ERROR     = 3'd7
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [CYCLES_WIDTH-1:0] run_cycles_q;
    logic [CYCLES_WIDTH-1:0] cycle_cnt_q;
    logic [TO_W-1:0]         timeout_q;
    logic                    aborted_q;
    logic [3:0]              final_count_q;

    logic                    accept;
    logic                    abort_honoured;
    logic                    timeout_hit;
    logic                    run_last;
    logic                    in_wait;

    // Abort beats a simultaneous request in IDLE, so accept is gated by it.
    assign accept = (state_q == S_IDLE) && bus.Run_Valid_In && !bus.Abort_In;

    // Abort only matters before the Stop pulse has been committed.
    assign abort_honoured = bus.Abort_In &&
                            ((state_q == S_START) ||
                             (state_q == S_WAIT_RUN) ||
                             (state_q == S_RUNNING));

    // Wait cycle k after a pulse sees timeout_q = k-1; the command pulse cycle
    // is counted too, so ERROR is entered ACK_TIMEOUT cycles after the pulse.
    assign timeout_hit = (timeout_q == TO_W'(ACK_TIMEOUT - 2));

    // RUNNING is only entered with a non-zero run length.
    assign run_last = (cycle_cnt_q == (run_cycles_q - CYCLES_WIDTH'(1)));

    assign in_wait = (state_q == S_WAIT_RUN) || (state_q == S_WAIT_HALT);

    // Next-state logic for the run sequence.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (bus.Run_Cycles_In == '0) ? S_DONE : S_START;
                end
            end
            S_START: begin
                state_d = bus.Abort_In ? S_STOP : S_WAIT_RUN;
            end
            S_WAIT_RUN: begin
                if (bus.Abort_In) begin
                    state_d = S_STOP;
                end else if (bus.Counter_Running_Flag_In) begin
                    state_d = S_RUNNING;
                end else if (timeout_hit) begin
                    state_d = S_ERROR;
                end
            end
            S_RUNNING: begin
                if (bus.Abort_In) begin
                    state_d = S_STOP;
                end else if (!bus.Counter_Running_Flag_In) begin
                    state_d = S_ERROR;
                end else if (run_last) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                state_d = S_WAIT_HALT;
            end
            S_WAIT_HALT: begin
                if (!bus.Counter_Running_Flag_In) begin
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    state_d = S_ERROR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERROR: begin
                if (bus.Error_Clear_In) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; asynchronous reset drops any command pulse at once.
    always_ff @(posedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the requested run length on accept.
    always_ff @(posedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            run_cycles_q <= '0;
        end else if (accept) begin
            run_cycles_q <= bus.Run_Cycles_In;
        end
    end

    // Cycles spent in RUNNING; zero everywhere else so entry starts clean.
    always_ff @(posedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            cycle_cnt_q <= '0;
        end else if (state_q == S_RUNNING) begin
            cycle_cnt_q <= cycle_cnt_q + CYCLES_WIDTH'(1);
        end else begin
            cycle_cnt_q <= '0;
        end
    end

    // Acknowledge timeout; counts only while waiting on the running flag.
    always_ff @(posedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            timeout_q <= '0;
        end else if (in_wait && !timeout_hit) begin
            timeout_q <= timeout_q + TO_W'(1);
        end else begin
            timeout_q <= '0;
        end
    end

    // Sticky abort marker for the run in flight, cleared by the next accept.
    always_ff @(posedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            aborted_q <= 1'b0;
        end else if (accept) begin
            aborted_q <= 1'b0;
        end else if (abort_honoured) begin
            aborted_q <= 1'b1;
        end
    end

    // Capture the count on the edge entering DONE so it is valid with the
    // Done pulse and held afterwards.
    always_ff @(posedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            final_count_q <= 4'b0001;
        end else if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            final_count_q <= bus.Counter_Count_In;
        end
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        bus.Run_Ready_Out             = (state_q == S_IDLE);
        bus.Run_Busy_Out              = (state_q != S_IDLE);
        bus.Start_Counter_Command_Out = (state_q == S_START);
        bus.Stop_Counter_Command_Out  = (state_q == S_STOP);
        bus.Run_Done_Out              = (state_q == S_DONE);
        bus.Run_Aborted_Out           = (state_q == S_DONE) && aborted_q;
        bus.Error_Out                 = (state_q == S_ERROR);
        bus.Final_Count_Out           = final_count_q;
        Debug_State_Out               = state_q;
    end

endmodule
